// File: rtl/mycpu_pkg.sv
// Shared CPU I/O definitions: I/O-space register addresses
// and STATUS register bit positions.
package mycpu_pkg;

  typedef logic [3:0] io_addr_t;

  localparam io_addr_t IO_OUT0   = 4'h0;
  localparam io_addr_t IO_OUT1   = 4'h1;
  localparam io_addr_t IO_STATUS = 4'h2;
  localparam io_addr_t IO_RXDATA = 4'h3;
  localparam io_addr_t IO_TCOUNT = 4'h4;
  localparam io_addr_t IO_TCMP   = 4'h5;
  localparam io_addr_t IO_CLEAR  = 4'h6;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_TFLAG = 3;

endpackage

// File: rtl/io_fifo.sv
// Receive byte FIFO (DEPTH entries, power of two).
// Ports: clk, rst_n, wdata/push, pop, full, empty, head.
module io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wdata,
  input  logic       push,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_unit.sv
// CPU I/O block: OUT0/OUT1, STATUS, RX FIFO, optional timer.
// Ports: CPU bus (a_in,d_in,wen_in,iom_in,io_out), out0_out,
// out1_out, rx_data_in/rx_valid_in/rx_ready_out, irq_out.
// Timer built only when IO_UNIT_TIMER_EN is defined.
module io_unit
  import mycpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_in,
  input  logic [15:0] d_in,
  input  logic        wen_in,
  input  logic        iom_in,
  output logic [15:0] io_out,
  output logic [15:0] out0_out,
  output logic [15:0] out1_out,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        rx_ready_out,
  output logic        irq_out
);

  io_addr_t    addr;
  logic        wr;
  logic        wr_out0;
  logic        wr_out1;
  logic        wr_rx;
  logic        wr_clr;
  logic        full;
  logic        empty;
  logic [7:0]  head;
  logic        ovf;
  logic        tflag;
  logic [15:0] tcount;
  logic [15:0] tcmp;
  logic [15:0] status;
  logic        unused_addr;

  assign addr        = a_in[3:0];
  assign unused_addr = ^a_in[15:4];
  assign wr          = iom_in & wen_in;
  assign wr_out0     = wr & (addr == IO_OUT0);
  assign wr_out1     = wr & (addr == IO_OUT1);
  assign wr_rx       = wr & (addr == IO_RXDATA);
  assign wr_clr      = wr & (addr == IO_CLEAR);

  io_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .wdata(rx_data_in),
    .push (rx_valid_in),
    .pop  (wr_rx),
    .full (full),
    .empty(empty),
    .head (head)
  );

  assign rx_ready_out = ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_out <= '0;
      out1_out <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_out0) out0_out <= d_in;
      if (wr_out1) out1_out <= d_in;
      if (rx_valid_in & full)   ovf <= 1'b1;
      else if (wr_clr & d_in[0]) ovf <= 1'b0;
    end
  end

`ifdef IO_UNIT_TIMER_EN
  logic wr_tcmp;
  logic match;

  assign wr_tcmp = wr & (addr == IO_TCMP);
  assign match   = (tcount == tcmp);

  // Match uses the registered TCMP, so a new compare value
  // takes effect from the cycle after its write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount <= '0;
      tcmp   <= 16'hFFFF;
      tflag  <= 1'b0;
    end else begin
      tcount <= match ? '0 : tcount + 1'b1;
      if (wr_tcmp) tcmp <= d_in;
      if (match)                 tflag <= 1'b1;
      else if (wr_clr & d_in[1]) tflag <= 1'b0;
    end
  end
`else
  assign tcount = '0;
  assign tcmp   = '0;
  assign tflag  = 1'b0;
`endif

  assign irq_out = tflag;

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
    status[ST_OVF]   = ovf;
    status[ST_TFLAG] = tflag;
  end

  always_comb begin
    io_out = '0;
    case (addr)
      IO_OUT0:   io_out = out0_out;
      IO_OUT1:   io_out = out1_out;
      IO_STATUS: io_out = status;
      IO_RXDATA: io_out = empty ? 16'h0 : {8'h00, head};
      IO_TCOUNT: io_out = tcount;
      IO_TCMP:   io_out = tcmp;
      default:   io_out = '0;
    endcase
  end

endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit with an RX scoreboard.
// Timer checks follow IO_UNIT_TIMER_EN.
module tb_io_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] d_in;
  logic        wen_in;
  logic        iom_in;
  logic [15:0] io_out;
  logic [15:0] out0_out;
  logic [15:0] out1_out;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic        irq_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic       ovf_m;
  logic [15:0] v;

  io_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_in        (a_in),
    .d_in        (d_in),
    .wen_in      (wen_in),
    .iom_in      (iom_in),
    .io_out      (io_out),
    .out0_out    (out0_out),
    .out1_out    (out1_out),
    .rx_data_in  (rx_data_in),
    .rx_valid_in (rx_valid_in),
    .rx_ready_out(rx_ready_out),
    .irq_out     (irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] val);
    a_in = {12'h0, a};
    #1;
    val = io_out;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    a_in   = {12'h0, a};
    d_in   = d;
    iom_in = 1'b1;
    wen_in = 1'b1;
    tick();
    iom_in = 1'b0;
    wen_in = 1'b0;
  endtask

  function automatic logic [15:0] exp_status(input logic tf);
    logic [15:0] s;
    s    = '0;
    s[0] = (sb.size() == 0);
    s[1] = (sb.size() == DEPTH);
    s[2] = ovf_m;
    s[3] = tf;
    return s;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    logic [15:0] st;
    check("rx_ready", {15'h0, rx_ready_out},
          {15'h0, sb.size() < DEPTH});
    rx_data_in  = b;
    rx_valid_in = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(b);
    else ovf_m = 1'b1;
    tick();
    rx_valid_in = 1'b0;
    st = '0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] h;
    logic [7:0]  e;
    rd(4'h3, h);
    if (sb.size() == 0) begin
      check(tag, h, 16'h0);
    end else begin
      e = sb.pop_front();
      check(tag, h, {8'h00, e});
    end
    wr(4'h3, 16'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_t;
    logic fl;
    rst_n       = 1'b0;
    a_in        = 16'h2;
    d_in        = '0;
    wen_in      = 1'b0;
    iom_in      = 1'b0;
    rx_data_in  = '0;
    rx_valid_in = 1'b0;
    ovf_m       = 1'b0;
    #1;
    check("rst_status", io_out, 16'h0001);
    check("rst_ready", {15'h0, rx_ready_out}, 16'h1);
    check("rst_irq", {15'h0, irq_out}, 16'h0);
    check("rst_out0", out0_out, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;

    wr(4'h0, 16'hA5A5);
    check("out0_wr", out0_out, 16'hA5A5);
    rd(4'h0, v);
    check("out0_rd", v, 16'hA5A5);
    a_in   = 16'h0;
    d_in   = 16'h1111;
    wen_in = 1'b1;
    iom_in = 1'b0;
    tick();
    wen_in = 1'b0;
    check("out0_iom0", out0_out, 16'hA5A5);
    wr(4'h1, 16'h5A5A);
    check("out1_wr", out1_out, 16'h5A5A);
    wr(4'h9, 16'hFFFF);
    rd(4'h9, v);
    check("unmapped", v, 16'h0);
    check("out0_keep", out0_out, 16'hA5A5);

    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("full_ready", {15'h0, rx_ready_out}, 16'h0);
    rd(4'h2, v);
    check("full_status", v, exp_status(1'b0));
    push_byte(8'h09);
    rd(4'h2, v);
    check("ovf_status", v, exp_status(1'b0));
    for (int i = 0; i < 8; i++) pop_check("pop_order");
    rd(4'h2, v);
    check("drain_status", v, exp_status(1'b0));
    wr(4'h6, 16'h0001);
    ovf_m = 1'b0;
    rd(4'h2, v);
    check("clr_ovf", v, exp_status(1'b0));

    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    rd(4'h3, v);
    check("sim_head", v, {8'h00, sb[0]});
    a_in        = 16'h3;
    iom_in      = 1'b1;
    wen_in      = 1'b1;
    rx_data_in  = 8'h55;
    rx_valid_in = 1'b1;
    tick();
    iom_in      = 1'b0;
    wen_in      = 1'b0;
    rx_valid_in = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h55);
    pop_check("sim_pop1");
    pop_check("sim_pop2");
    pop_check("sim_55");
    rd(4'h2, v);
    check("sim_empty", v, exp_status(1'b0));

    wr(4'h3, 16'h0);
    rd(4'h2, v);
    check("empty_pop", v, exp_status(1'b0));
    push_byte(8'h77);
    pop_check("after_empty_pop");

    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    wr(4'h1, 16'h1234);
    check("out1_1234", out1_out, 16'h1234);
    #2;
    rst_n = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    #1;
    check("arst_out1", out1_out, 16'h0);
    check("arst_ready", {15'h0, rx_ready_out}, 16'h1);
    rd(4'h2, v);
    check("arst_status", v, exp_status(1'b0));
`ifdef IO_UNIT_TIMER_EN
    rd(4'h5, v);
    check("arst_tcmp", v, 16'hFFFF);
`endif
    #1;
    rst_n = 1'b1;

`ifdef IO_UNIT_TIMER_EN
    wr(4'h5, 16'h0004);
    rd(4'h5, v);
    check("tcmp_wr", v, 16'h0004);
    exp_t = 1;
    fl    = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rd(4'h4, v);
      check("tcount", v, 16'(exp_t));
      check("irq", {15'h0, irq_out}, {15'h0, fl});
      tick();
      if (exp_t == 4) begin
        exp_t = 0;
        fl    = 1'b1;
      end else begin
        exp_t++;
      end
    end
    while (exp_t == 4) begin
      tick();
      exp_t = 0;
    end
    wr(4'h6, 16'h0002);
    check("irq_clr", {15'h0, irq_out}, 16'h0);
`else
    wr(4'h5, 16'h1234);
    rd(4'h5, v);
    check("notimer_tcmp", v, 16'h0);
    rd(4'h4, v);
    check("notimer_tcount", v, 16'h0);
    for (int i = 0; i < 6; i++) tick();
    check("notimer_irq", {15'h0, irq_out}, 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
